// File: rtl/bp_be_issue_queue.sv
// -----------------------------------------------------------------------------
// bp_be_issue_queue
//
// Buffered BE issue stage. FE queue packets are predecoded into issue packets
// as they are written and held in a depth_p-entry circular buffer. Three
// pointers track the buffer:
//    wptr - next slot to write
//    rptr - next entry to present to the calculator (speculative issue)
//    cptr - oldest entry not yet committed
// Entries stay resident from issue until commit, so a cache-miss roll only
// has to move rptr back to cptr to replay them.
//
// Optional feature macro: BP_BE_ISSUE_BYPASS_EN
//    defined   : an enqueue into an empty issue window (rptr == wptr) with no
//                roll/flush drives issue_pkt_o combinationally the same cycle
//    undefined : issue_pkt_o comes from the buffer only (1-cycle latency)
//
// Ports
//    clk_i              clock, rising edge
//    reset_n_i          asynchronous active-low reset
//    fe_queue_i         FE packet (fetch or exception)
//    fe_queue_v_i       FE packet valid
//    fe_queue_ready_o   buffer can accept a packet this cycle
//    issue_pkt_o        predecoded packet at rptr (or bypassed packet)
//    issue_pkt_v_o      issue_pkt_o valid
//    issue_pkt_ready_i  calculator accepts issue_pkt_o
//    cache_miss_v_i     roll: rptr returns to cptr, no issue this cycle
//    cmt_v_i            retire the oldest issued entry
//    flush_i            discard every entry (dominates everything else)
//    count_o            resident entries, wptr - cptr
//
// FE packet layout (MSB..LSB):
//    msg_type(1, 1=exception) | pc/vaddr | instr(32) | branch metadata | exc code(2)
// Issue packet layout (MSB..LSB):
//    fe_exception_not_instr | fe_exception_code(2) | pc | branch_metadata_fwd |
//    instr(32) | irs1_v | irs2_v | frs1_v | frs2_v | fence_v | imm(64)
// -----------------------------------------------------------------------------
module bp_be_issue_queue #(
   // Processor configuration selector; 0 is e_bp_inv_cfg. Every configuration
   // currently resolves to the same vaddr / branch-metadata widths.
   parameter int cfg_p   = 0,
   parameter int depth_p = 8,
   localparam int vaddr_width_p               = (cfg_p == 0) ? 39 : 39,
   localparam int branch_metadata_fwd_width_p = (cfg_p == 0) ? 35 : 35,
   localparam int ptr_width_lp                = $clog2(depth_p) + 1,
   localparam int fe_queue_width_lp  = 1 + vaddr_width_p + 32 + branch_metadata_fwd_width_p + 2,
   localparam int issue_pkt_width_lp = 3 + vaddr_width_p + branch_metadata_fwd_width_p + 32 + 5 + 64
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [fe_queue_width_lp-1:0]  fe_queue_i,
   input  logic                          fe_queue_v_i,
   output logic                          fe_queue_ready_o,
   output logic [issue_pkt_width_lp-1:0] issue_pkt_o,
   output logic                          issue_pkt_v_o,
   input  logic                          issue_pkt_ready_i,
   input  logic                          cache_miss_v_i,
   input  logic                          cmt_v_i,
   input  logic                          flush_i,
   output logic [ptr_width_lp-1:0]       count_o
);

   typedef struct packed {
      logic                                   msg_type;
      logic [vaddr_width_p-1:0]               pc;
      logic [31:0]                            instr;
      logic [branch_metadata_fwd_width_p-1:0] branch_metadata;
      logic [1:0]                             exc_code;
   } fe_queue_s;

   typedef struct packed {
      logic                                   fe_exception_not_instr;
      logic [1:0]                             fe_exception_code;
      logic [vaddr_width_p-1:0]               pc;
      logic [branch_metadata_fwd_width_p-1:0] branch_metadata_fwd;
      logic [31:0]                            instr;
      logic                                   irs1_v;
      logic                                   irs2_v;
      logic                                   frs1_v;
      logic                                   frs2_v;
      logic                                   fence_v;
      logic [63:0]                            imm;
   } issue_pkt_s;

   localparam logic [6:0] op_load_lp      = 7'b0000011;
   localparam logic [6:0] op_misc_mem_lp  = 7'b0001111;
   localparam logic [6:0] op_op_imm_lp    = 7'b0010011;
   localparam logic [6:0] op_auipc_lp     = 7'b0010111;
   localparam logic [6:0] op_op_imm_32_lp = 7'b0011011;
   localparam logic [6:0] op_store_lp     = 7'b0100011;
   localparam logic [6:0] op_amo_lp       = 7'b0101111;
   localparam logic [6:0] op_op_lp        = 7'b0110011;
   localparam logic [6:0] op_lui_lp       = 7'b0110111;
   localparam logic [6:0] op_op_32_lp     = 7'b0111011;
   localparam logic [6:0] op_branch_lp    = 7'b1100011;
   localparam logic [6:0] op_jalr_lp      = 7'b1100111;
   localparam logic [6:0] op_jal_lp       = 7'b1101111;
   localparam logic [6:0] op_system_lp    = 7'b1110011;

   localparam logic [ptr_width_lp-1:0] depth_lp   = ptr_width_lp'(depth_p);
   localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

   fe_queue_s  fe_pkt;
   issue_pkt_s dec_pkt;
   logic [31:0] instr;
   logic [63:0] imm_u, imm_j, imm_b, imm_s, imm_i, imm_c;

   logic [ptr_width_lp-1:0] wptr_q, wptr_d;
   logic [ptr_width_lp-1:0] rptr_q, rptr_d;
   logic [ptr_width_lp-1:0] cptr_q, cptr_d;

   logic [issue_pkt_width_lp-1:0] mem_q [depth_p];

   logic full, enq, issue, cmt;

   assign fe_pkt = fe_queue_i;
   assign instr  = fe_pkt.instr;

   // RISC-V immediate formats, sign-extended to 64 bits. The CSR form is the
   // zero-extended 5-bit zimm carried in the rs1 field.
   assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
   assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_i = {{52{instr[31]}}, instr[31:20]};
   assign imm_c = {59'b0, instr[19:15]};

   // Predecode of the incoming packet; the buffer stores this result.
   always_comb begin
      dec_pkt = '0;
      if (fe_pkt.msg_type) begin
         dec_pkt.fe_exception_not_instr = 1'b1;
         dec_pkt.fe_exception_code      = fe_pkt.exc_code;
         dec_pkt.pc                     = fe_pkt.pc;
      end else begin
         dec_pkt.pc                  = fe_pkt.pc;
         dec_pkt.branch_metadata_fwd = fe_pkt.branch_metadata;
         dec_pkt.instr               = instr;
         dec_pkt.fence_v             = (instr[6:0] == op_misc_mem_lp);
         case (instr[6:0])
            op_lui_lp, op_auipc_lp: dec_pkt.imm = imm_u;
            op_jal_lp:              dec_pkt.imm = imm_j;
            op_jalr_lp, op_load_lp, op_op_imm_lp, op_op_imm_32_lp: begin
               dec_pkt.irs1_v = 1'b1;
               dec_pkt.imm    = imm_i;
            end
            op_branch_lp: begin
               dec_pkt.irs1_v = 1'b1;
               dec_pkt.irs2_v = 1'b1;
               dec_pkt.imm    = imm_b;
            end
            op_store_lp: begin
               dec_pkt.irs1_v = 1'b1;
               dec_pkt.irs2_v = 1'b1;
               dec_pkt.imm    = imm_s;
            end
            op_op_lp, op_op_32_lp, op_amo_lp: begin
               dec_pkt.irs1_v = 1'b1;
               dec_pkt.irs2_v = 1'b1;
            end
            op_system_lp: begin
               dec_pkt.irs1_v = 1'b1;
               dec_pkt.imm    = imm_c;
            end
            default: ;
         endcase
      end
   end

   // Occupancy is measured against cptr: issued-but-uncommitted entries still
   // hold their slot. Full uses pre-edge state, so a same-cycle commit does
   // not open a slot for a same-cycle enqueue.
   assign count_o = wptr_q - cptr_q;
   assign full    = (count_o == depth_lp);

   // Held low during reset so nothing is accepted while reset_n_i is low.
   assign fe_queue_ready_o = ~full & ~flush_i & reset_n_i;
   assign enq              = fe_queue_v_i & fe_queue_ready_o;

`ifdef BP_BE_ISSUE_BYPASS_EN
   logic bypass_v;
   assign bypass_v      = (rptr_q == wptr_q) & enq & ~cache_miss_v_i & ~flush_i;
   assign issue_pkt_v_o = ((rptr_q != wptr_q) | bypass_v) & ~cache_miss_v_i & ~flush_i;
   assign issue_pkt_o   = bypass_v ? dec_pkt : mem_q[rptr_q[ptr_width_lp-2:0]];
`else
   assign issue_pkt_v_o = (rptr_q != wptr_q) & ~cache_miss_v_i & ~flush_i;
   assign issue_pkt_o   = mem_q[rptr_q[ptr_width_lp-2:0]];
`endif

   assign issue = issue_pkt_v_o & issue_pkt_ready_i;
   // Only issued entries can retire; a commit during a roll is dropped.
   assign cmt   = cmt_v_i & ~cache_miss_v_i & (cptr_q != rptr_q);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cptr_d = cptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cptr_d = '0;
      end else begin
         if (enq) begin
            wptr_d = wptr_q + ptr_one_lp;
         end
         if (cache_miss_v_i) begin
            rptr_d = cptr_q;
         end else if (issue) begin
            rptr_d = rptr_q + ptr_one_lp;
         end
         if (cmt) begin
            cptr_d = cptr_q + ptr_one_lp;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cptr_q <= cptr_d;
      end
   end

   // Payload storage needs no reset: an entry is only read once written.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wptr_q[ptr_width_lp-2:0]] <= dec_pkt;
      end
   end

endmodule

// File: tb/tb_bp_be_issue_queue.sv
module tb_bp_be_issue_queue;

   localparam int DEPTH = 8;
   localparam int VW    = 39;
   localparam int BW    = 35;
   localparam int PW    = $clog2(DEPTH) + 1;
   localparam int FEW   = 1 + VW + 32 + BW + 2;
   localparam int IPW   = 3 + VW + BW + 32 + 5 + 64;

   logic           clk_i;
   logic           reset_n_i;
   logic [FEW-1:0] fe_queue_i;
   logic           fe_queue_v_i;
   logic           fe_queue_ready_o;
   logic [IPW-1:0] issue_pkt_o;
   logic           issue_pkt_v_o;
   logic           issue_pkt_ready_i;
   logic           cache_miss_v_i;
   logic           cmt_v_i;
   logic           flush_i;
   logic [PW-1:0]  count_o;

   bp_be_issue_queue #(.cfg_p(0), .depth_p(DEPTH)) dut (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .fe_queue_i        (fe_queue_i),
      .fe_queue_v_i      (fe_queue_v_i),
      .fe_queue_ready_o  (fe_queue_ready_o),
      .issue_pkt_o       (issue_pkt_o),
      .issue_pkt_v_o     (issue_pkt_v_o),
      .issue_pkt_ready_i (issue_pkt_ready_i),
      .cache_miss_v_i    (cache_miss_v_i),
      .cmt_v_i           (cmt_v_i),
      .flush_i           (flush_i),
      .count_o           (count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;
   logic [IPW-1:0] sb [$];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [BW-1:0] meta_of(input logic [VW-1:0] pc);
      return BW'(pc * 3) ^ 35'h5A5A5;
   endfunction

   function automatic logic [FEW-1:0] fe_fetch(input logic [VW-1:0] pc, input logic [31:0] instr);
      return {1'b0, pc, instr, meta_of(pc), 2'b00};
   endfunction

   function automatic logic [IPW-1:0] exp_fetch(input logic [VW-1:0] pc, input logic [31:0] instr,
                                                input logic rs1v, input logic rs2v,
                                                input logic fence, input logic [63:0] imm);
      return {1'b0, 2'b00, pc, meta_of(pc), instr, rs1v, rs2v, 1'b0, 1'b0, fence, imm};
   endfunction

   function automatic logic [31:0] op_instr(input int i);
      return {7'b0, 5'd2, 5'd1, 3'b000, 5'(i + 3), 7'b0110011};
   endfunction

   // Drives one packet for one cycle; the packet is expected to be accepted.
   task automatic enq(input logic [FEW-1:0] fe, input logic [IPW-1:0] exp);
      fe_queue_i   = fe;
      fe_queue_v_i = 1'b1;
      sb.push_back(exp);
      #1;
      check("enq_rdy", 256'(fe_queue_ready_o), 256'(1));
      tick();
      fe_queue_v_i = 1'b0;
   endtask

   task automatic enq_op(input logic [VW-1:0] pc, input int i);
      enq(fe_fetch(pc, op_instr(i)), exp_fetch(pc, op_instr(i), 1'b1, 1'b1, 1'b0, 64'd0));
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      issue_pkt_ready_i = 1'b1;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      check(tag, 256'(sb.size()), 256'(0));
      issue_pkt_ready_i = 1'b0;
   endtask

   task automatic commit(input int n);
      cmt_v_i = 1'b1;
      repeat (n) tick();
      cmt_v_i = 1'b0;
   endtask

   // Scoreboard: every issue handshake pops the next expected packet.
   always @(negedge clk_i) begin
      if (reset_n_i && issue_pkt_v_o && issue_pkt_ready_i) begin
         if (sb.size() == 0) begin
            check("unexp_issue", 256'(issue_pkt_v_o), 256'(0));
         end else begin
            logic [IPW-1:0] e;
            e = sb.pop_front();
            $display("issue pc=%0h exp_pc=%0h", issue_pkt_o[IPW-4 -: VW], e[IPW-4 -: VW]);
            check("issue_pkt", 256'(issue_pkt_o), 256'(e));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      logic [VW-1:0] pc;
      reset_n_i         = 1'b0;
      fe_queue_v_i      = 1'b1;
      fe_queue_i        = fe_fetch(39'h100, op_instr(0));
      issue_pkt_ready_i = 1'b0;
      cache_miss_v_i    = 1'b0;
      cmt_v_i           = 1'b0;
      flush_i           = 1'b0;

      // Reset
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_cnt", 256'(count_o), 256'(0));
      check("rst_v", 256'(issue_pkt_v_o), 256'(0));
      check("rst_rdy", 256'(fe_queue_ready_o), 256'(0));
      reset_n_i    = 1'b1;
      fe_queue_v_i = 1'b0;
      #1;
      check("post_rst_rdy", 256'(fe_queue_ready_o), 256'(1));
      check("post_rst_cnt", 256'(count_o), 256'(0));

      // Fill to depth; the ninth packet must be refused
      for (int i = 0; i < DEPTH; i++) enq_op(VW'(32'h1000 + 4 * i), i);
      check("full_cnt", 256'(count_o), 256'(8));
      check("full_rdy", 256'(fe_queue_ready_o), 256'(0));
      fe_queue_i   = fe_fetch(39'h1FFC, op_instr(9));
      fe_queue_v_i = 1'b1;
      tick();
      fe_queue_v_i = 1'b0;
      check("ninth_cnt", 256'(count_o), 256'(8));
      drain("fill_drain");
      commit(DEPTH);
      check("fill_cmt_cnt", 256'(count_o), 256'(0));

      // LOAD imm=-4, issue latency
      ins = {12'hFFC, 5'd1, 3'b011, 5'd5, 7'b0000011};
      issue_pkt_ready_i = 1'b1;
      fe_queue_i   = fe_fetch(39'h4000, ins);
      fe_queue_v_i = 1'b1;
      sb.push_back(exp_fetch(39'h4000, ins, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC));
      #1;
`ifdef BP_BE_ISSUE_BYPASS_EN
      check("lat_v0", 256'(issue_pkt_v_o), 256'(1));
`else
      check("lat_v0", 256'(issue_pkt_v_o), 256'(0));
`endif
      tick();
      fe_queue_v_i = 1'b0;
      #1;
`ifdef BP_BE_ISSUE_BYPASS_EN
      check("lat_v1", 256'(issue_pkt_v_o), 256'(0));
`else
      check("lat_v1", 256'(issue_pkt_v_o), 256'(1));
`endif
      tick();
      issue_pkt_ready_i = 1'b0;
      check("lat_sb", 256'(sb.size()), 256'(0));
      commit(1);
      check("lat_cmt_cnt", 256'(count_o), 256'(0));

      // Other opcode classes and an exception packet
      ins = {7'h7F, 5'd2, 5'd1, 3'b011, 5'h10, 7'b0100011};
      enq(fe_fetch(39'h5000, ins), exp_fetch(39'h5000, ins, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0));
      ins = {1'b1, 6'h3F, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'b1100011};
      enq(fe_fetch(39'h5004, ins), exp_fetch(39'h5004, ins, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8));
      ins = {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'b1101111};
      enq(fe_fetch(39'h5008, ins), exp_fetch(39'h5008, ins, 1'b0, 1'b0, 1'b0, 64'h800));
      ins = {20'h80001, 5'd4, 7'b0110111};
      enq(fe_fetch(39'h500C, ins), exp_fetch(39'h500C, ins, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_1000));
      ins = {12'h300, 5'd17, 3'b101, 5'd0, 7'b1110011};
      enq(fe_fetch(39'h5010, ins), exp_fetch(39'h5010, ins, 1'b1, 1'b0, 1'b0, 64'd17));
      ins = 32'h0FF0_000F;
      enq(fe_fetch(39'h5014, ins), exp_fetch(39'h5014, ins, 1'b0, 1'b0, 1'b1, 64'd0));
      ins = {12'd5, 5'd6, 3'b000, 5'd7, 7'b0011011};
      enq(fe_fetch(39'h5018, ins), exp_fetch(39'h5018, ins, 1'b1, 1'b0, 1'b0, 64'd5));
      enq({1'b1, 39'h7777, 32'hDEAD_BEEF, 35'h123, 2'b10},
          {1'b1, 2'b10, 39'h7777, 35'b0, 32'b0, 5'b0, 64'b0});
      drain("opc_drain");
      commit(8);
      check("opc_cmt_cnt", 256'(count_o), 256'(0));

      // Roll: issue A,B,C; commit A; roll replays B,C
      enq_op(39'h2000, 0);
      enq_op(39'h2004, 1);
      enq_op(39'h2008, 2);
      drain("roll_pre");
      commit(1);
      check("roll_cnt", 256'(count_o), 256'(2));
      sb.push_back(exp_fetch(39'h2004, op_instr(1), 1'b1, 1'b1, 1'b0, 64'd0));
      sb.push_back(exp_fetch(39'h2008, op_instr(2), 1'b1, 1'b1, 1'b0, 64'd0));
      cache_miss_v_i    = 1'b1;
      issue_pkt_ready_i = 1'b1;
      #1;
      check("roll_v", 256'(issue_pkt_v_o), 256'(0));
      tick();
      cache_miss_v_i = 1'b0;
      drain("roll_replay");

      // Commit together with roll: commit dropped, rptr back to cptr
      cmt_v_i        = 1'b1;
      cache_miss_v_i = 1'b1;
      tick();
      cmt_v_i        = 1'b0;
      cache_miss_v_i = 1'b0;
      check("cmtroll_cnt", 256'(count_o), 256'(2));
      sb.push_back(exp_fetch(39'h2004, op_instr(1), 1'b1, 1'b1, 1'b0, 64'd0));
      sb.push_back(exp_fetch(39'h2008, op_instr(2), 1'b1, 1'b1, 1'b0, 64'd0));
      drain("cmtroll_replay");
      commit(2);
      check("cmtroll_cmt_cnt", 256'(count_o), 256'(0));

      // 20 rounds across the pointer wrap
      issue_pkt_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cmt_v_i = ((i % 4) != 0);
         pc = VW'(32'h3000 + 4 * i);
         enq_op(pc, i);
         check("wrap_cnt_le8", 256'(count_o <= PW'(DEPTH)), 256'(1));
      end
      cmt_v_i = 1'b0;
      drain("wrap_drain");
      commit(DEPTH);
      check("wrap_cmt_cnt", 256'(count_o), 256'(0));

      // Flush with 5 resident entries and a same-cycle enqueue
      issue_pkt_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fe_queue_i   = fe_fetch(VW'(32'h6000 + 4 * i), op_instr(i));
         fe_queue_v_i = 1'b1;
         tick();
      end
      fe_queue_v_i = 1'b0;
      check("fl_cnt5", 256'(count_o), 256'(5));
      fe_queue_i   = fe_fetch(39'h6FFC, op_instr(7));
      fe_queue_v_i = 1'b1;
      flush_i      = 1'b1;
      #1;
      check("fl_rdy", 256'(fe_queue_ready_o), 256'(0));
      check("fl_v", 256'(issue_pkt_v_o), 256'(0));
      tick();
      flush_i      = 1'b0;
      fe_queue_v_i = 1'b0;
      #1;
      check("fl_cnt0", 256'(count_o), 256'(0));
      check("fl_v_after", 256'(issue_pkt_v_o), 256'(0));
      issue_pkt_ready_i = 1'b1;
      repeat (3) tick();
      issue_pkt_ready_i = 1'b0;
      check("sb_empty", 256'(sb.size()), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bp_be_issue_queue.md
# bp_be_issue_queue

Parametrised, buffered successor to the BE scheduler: accepts FE queue packets, predecodes them into issue packets at enqueue, and holds them in a `depth_p`-entry circular buffer until commit. It sits between the FE queue and the calculator. It owns the speculative-issue / commit / roll pointers internally, so the FE queue no longer needs roll/deq side-band control. Entries stay resident from issue until commit so a cache-miss roll can replay them.

## Interface
Parameters:
- `cfg_p`, `e_bp_inv_cfg`: processor configuration; supplies `vaddr_width_p` and `branch_metadata_fwd_width_p`.
- `depth_p`, 8: number of buffer entries; power of two, ≥2.
- `ptr_width_lp` (localparam), `$clog2(depth_p)+1`: pointer width, including the wrap bit.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `fe_queue_i`  in  `fe_queue_width_lp`  FE packet, fetch or exception.
- `fe_queue_v_i`  in  1  FE packet valid.
- `fe_queue_ready_o`  out  1  buffer can accept a packet.
- `issue_pkt_o`  out  `issue_pkt_width_lp`  predecoded packet at the speculative read pointer.
- `issue_pkt_v_o`  out  1  `issue_pkt_o` is valid.
- `issue_pkt_ready_i`  in  1  calculator accepts the packet.
- `cache_miss_v_i`  in  1  roll: replay from the oldest uncommitted entry.
- `cmt_v_i`  in  1  retire the oldest issued entry.
- `flush_i`  in  1  discard all entries.
- `count_o`  out  `ptr_width_lp`  resident entries, computed as `wptr - cptr`.

## Operation
- Three pointers, each `ptr_width_lp` wide and wrapping modulo 2·`depth_p`:
  - `wptr`: write pointer.
  - `rptr`: speculative issue pointer.
  - `cptr`: commit pointer.
- Predecode is applied when an entry is written; the entry stores the issue packet.
- Fetch predecode rules:
  - `irs1_v` is set for JALR, LOAD, OP_IMM, OP_IMM_32, SYSTEM, BRANCH, STORE, OP, OP_32, AMO.
  - `irs2_v` is set for BRANCH, STORE, OP, OP_32, AMO.
  - `frs1_v` and `frs2_v` are 0.
  - `fence_v` = (opcode == MISC_MEM).
  - Immediate: U-type for LUI/AUIPC, J-type for JAL, B-type for BRANCH, S-type for STORE, I-type for JALR/LOAD/OP_IMM/OP_IMM_32, C (CSR) for SYSTEM, otherwise 0.
- Exception predecode: `fe_exception_not_instr`=1, code copied, `pc`=vaddr, all other fields 0.
- Full condition: `count_o == depth_p`. `fe_queue_ready_o = ~full & ~flush_i`.
- Enqueue occurs on `fe_queue_v_i & fe_queue_ready_o`: write at `wptr`, then `wptr++`.
- Issue valid: `issue_pkt_v_o = (rptr != wptr) & ~cache_miss_v_i & ~flush_i`.
- Issue occurs on `issue_pkt_v_o & issue_pkt_ready_i`: `rptr++`.
- Commit occurs on `cmt_v_i & ~cache_miss_v_i & (cptr != rptr)`: `cptr++`.
  - A commit with `cptr == rptr` is ignored.
  - A commit coinciding with a roll is dropped.
- Roll (`cache_miss_v_i`): `rptr <= cptr`; no issue that cycle; enqueue still allowed.
- Flush (`flush_i`): all three pointers are set to 0. Flush dominates roll, commit, issue and enqueue.

## Timing
- Reset (asynchronous assert): all pointers 0, `count_o`=0, `issue_pkt_v_o`=0, `fe_queue_ready_o`=0 while `reset_n_i` is low. `fe_queue_ready_o`=1 in the first cycle after deassertion.
- Issue latency without bypass: a packet enqueued in cycle N is presented on `issue_pkt_o` in cycle N+1.
- Outputs are combinational from registered state only, except in bypass mode.
- Enqueue and issue in the same cycle are both allowed.
- Enqueue into the slot freed by a same-cycle commit is NOT allowed; full is evaluated on pre-edge state.
- Wrap: pointers compare including the wrap bit. `count_o` is the modular difference, range 0..`depth_p`.

## Configuration
- `BP_BE_ISSUE_BYPASS_EN` defined:
  - Condition: `rptr == wptr` and an enqueue occurs, with no roll or flush in that cycle.
  - In that case the freshly predecoded packet drives `issue_pkt_o` and `issue_pkt_v_o`=1 in the same cycle.
  - The entry is still written. If it is issued, `wptr` and `rptr` both increment.
  - Issue latency is 0 cycles.
- Undefined: no combinational path from `fe_queue_i` to `issue_pkt_o`; latency is 1 cycle.

## Test plan
- Reset, then 8 fetches (opcode OP, x1+x2) with `issue_pkt_ready_i`=0 → `count_o`=8, `fe_queue_ready_o`=0; the 9th packet is not accepted.
- Enqueue LOAD imm=-4, ready=1 → issued packet has `irs1_v`=1, `irs2_v`=0, imm=0xFFFF_FFFF_FFFF_FFFC. Latency is 1 cycle, or 0 with `BP_BE_ISSUE_BYPASS_EN`.
- Issue pc A,B,C; commit A; assert `cache_miss_v_i` → `issue_pkt_v_o`=0 that cycle; next issues are B then C again.
- Assert `cmt_v_i` and `cache_miss_v_i` together → `cptr` unchanged; `rptr` returns to `cptr`.
- Run 20 enqueue/issue/commit rounds at depth 8 (wrap) → pc order preserved; `count_o` never exceeds 8.
- With 5 entries resident, assert `flush_i` alongside `fe_queue_v_i` → packet not accepted; next cycle `count_o`=0, `issue_pkt_v_o`=0.
